// File: rtl/seq_det_pkg.sv
// Shared constants and width helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic [3:0] DEF_PAT_0101 = 4'b0101;
    localparam int         DEF_CNT_W    = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // fill counts 0..n inclusive, so it needs room for n+1 distinct values.
    function automatic int fill_w(input int n);
        return clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a simultaneous increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with run-time reloadable pattern, Moore and Mealy
// match outputs and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = N'(DEF_PAT_0101),
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = DEF_CNT_W,
    localparam int          FW      = fill_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             clr_count,
    output logic             moore_match,
    output logic             mealy_match,
    output logic [CNT_W-1:0] match_count,
    output logic [FW-1:0]    fill
);

    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_ARM  = FW'(N - 1);

    logic [N-1:0]  hist_q, hist_d, hist_shift;
    logic [N-1:0]  pat_q, pat_d;
    logic [FW-1:0] fill_q, fill_d, fill_inc;
    logic          moore_q;
    logic          match_now;

    // A match needs N-1 stored bits plus the current x; the fill guard keeps
    // the zeroed reset history from ever matching an all-zero pattern.
    always_comb begin
        hist_shift = {hist_q[N-2:0], x};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
        match_now  = en & ~pat_load & (fill_q >= FILL_ARM) & (hist_shift == pat_q);

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (en) begin
            hist_d = hist_shift;
            fill_d = (match_now && !OVERLAP) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
            moore_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            moore_q <= match_now;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rst_n(reset),
        .inc  (match_now),
        .clr  (clr_count),
        .count(match_count)
    );

    assign moore_match = moore_q;
    assign mealy_match = match_now;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three parameter variants share one stimulus stream
// and are checked every cycle against a queue-based model plus directed expectations.
module tb_seq_detector_param;

    localparam int N = 4;

    logic       clk;
    logic       reset;
    logic       x;
    logic       en;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       clr_count;

    logic       mealy_o[3];
    logic       moore_o[3];
    logic [7:0] cnt_o[3];
    logic [2:0] fill_o[3];
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    // dut0: defaults; dut1: non-overlapping; dut2: all-zero pattern, 2-bit counter
    seq_detector_param u_dut0 (
        .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
        .clr_count(clr_count), .moore_match(moore_o[0]), .mealy_match(mealy_o[0]),
        .match_count(cnt_o[0]), .fill(fill_o[0])
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
        .clr_count(clr_count), .moore_match(moore_o[1]), .mealy_match(mealy_o[1]),
        .match_count(cnt_o[1]), .fill(fill_o[1])
    );

    seq_detector_param #(.PATTERN(4'b0000), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .x(x), .en(en), .pat_load(pat_load), .pat_in(pat_in),
        .clr_count(clr_count), .moore_match(moore_o[2]), .mealy_match(mealy_o[2]),
        .match_count(cnt2), .fill(fill_o[2])
    );

    assign cnt_o[2] = {6'b0, cnt2};

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    // Bits received since the last reset; each variant remembers where its
    // current match window starts in this stream.
    bit         stream[$];
    int         start_m[3];
    int         cnt_m[3];
    bit         moore_m[3];
    logic [3:0] pat_m[3];
    int         cmax[3] = '{255, 255, 3};
    bit         ovl[3]  = '{1'b1, 1'b0, 1'b1};

    task automatic model_reset();
        stream.delete();
        for (int k = 0; k < 3; k++) begin
            start_m[k] = 0;
            cnt_m[k]   = 0;
            moore_m[k] = 1'b0;
        end
        pat_m[0] = 4'b0101;
        pat_m[1] = 4'b0101;
        pat_m[2] = 4'b0000;
    endtask

    function automatic bit model_match(input int k);
        int sz;
        sz = stream.size();
        if (!(en === 1'b1 && pat_load === 1'b0)) return 1'b0;
        if (sz - start_m[k] < N - 1) return 1'b0;
        for (int i = 0; i < N - 1; i++) begin
            if (stream[sz - (N - 1) + i] != pat_m[k][N - 1 - i]) return 1'b0;
        end
        return (x === pat_m[k][0]);
    endfunction

    function automatic int model_fill(input int k);
        int f;
        f = stream.size() - start_m[k];
        return (f > N) ? N : f;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            bit m[3];
            for (int k = 0; k < 3; k++) m[k] = model_match(k);
            for (int k = 0; k < 3; k++) begin
                if (clr_count) cnt_m[k] = 0;
                else if (m[k] && cnt_m[k] < cmax[k]) cnt_m[k] = cnt_m[k] + 1;
                moore_m[k] = m[k];
            end
            if (pat_load) begin
                for (int k = 0; k < 3; k++) begin
                    pat_m[k]   = pat_in;
                    start_m[k] = stream.size();
                end
            end else if (en) begin
                stream.push_back(x);
                for (int k = 0; k < 3; k++)
                    if (m[k] && !ovl[k]) start_m[k] = stream.size();
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("mealy%0d", k), int'(mealy_o[k]), int'(model_match(k)));
                chk($sformatf("moore%0d", k), int'(moore_o[k]), int'(moore_m[k]));
                chk($sformatf("count%0d", k), int'(cnt_o[k]), cnt_m[k]);
                chk($sformatf("fill%0d", k), int'(fill_o[k]), model_fill(k));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit xi, input bit ei, input bit li, input bit ci, input logic [3:0] pi);
        @(negedge clk);
        #1;
        x = xi;
        en = ei;
        pat_load = li;
        clr_count = ci;
        pat_in = pi;
    endtask

    task automatic samp(input bit xi);
        drive(xi, 1'b1, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        x = 1'b0;
        en = 1'b0;
        pat_load = 1'b0;
        clr_count = 1'b0;
        pat_in = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b0;
        x = 1'b0;
        en = 1'b0;
        pat_load = 1'b0;
        clr_count = 1'b0;
        pat_in = 4'b0000;
        model_reset();
        after_edge();
        chk("rst_moore0", int'(moore_o[0]), 0);
        chk("rst_count0", int'(cnt_o[0]), 0);
        chk("rst_fill0", int'(fill_o[0]), 0);
        chk("rst_count2", int'(cnt_o[2]), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // overlapping 0101 detection
        samp(0); samp(1); samp(0); samp(1);
        #1;
        chk("t1_mealy0_s4", int'(mealy_o[0]), 1);
        chk("t1_mealy2_s4", int'(mealy_o[2]), 0);
        after_edge();
        chk("t1_moore0_s4", int'(moore_o[0]), 1);
        chk("t1_count0_s4", int'(cnt_o[0]), 1);
        samp(0);
        #1;
        chk("t1_mealy0_s5", int'(mealy_o[0]), 0);
        samp(1);
        #1;
        chk("t1_mealy0_s6", int'(mealy_o[0]), 1);
        chk("t1_mealy1_s6", int'(mealy_o[1]), 0);
        after_edge();
        chk("t1_moore0_s6", int'(moore_o[0]), 1);
        chk("t1_count0", int'(cnt_o[0]), 2);
        chk("t1_count1", int'(cnt_o[1]), 1);

        // non-overlapping restart
        do_reset();
        for (int i = 0; i < 8; i++) begin
            samp(bit'(i % 2));
            if (i == 3) begin
                after_edge();
                chk("t2_fill1_after_match", int'(fill_o[1]), 0);
                chk("t2_fill0_after_match", int'(fill_o[0]), 4);
            end
        end
        after_edge();
        chk("t2_count1", int'(cnt_o[1]), 2);
        chk("t2_count0", int'(cnt_o[0]), 3);
        chk("t2_moore1", int'(moore_o[1]), 1);
        chk("t2_fill1_end", int'(fill_o[1]), 0);

        // all-zero pattern and counter saturation
        do_reset();
        for (int i = 0; i < 8; i++) begin
            samp(0);
            if (i == 2) begin
                #1;
                chk("t3_mealy2_s3", int'(mealy_o[2]), 0);
            end
            if (i == 3) begin
                after_edge();
                chk("t3_moore2_s4", int'(moore_o[2]), 1);
            end
        end
        after_edge();
        chk("t3_count2_sat", int'(cnt_o[2]), 3);
        chk("t3_count0", int'(cnt_o[0]), 0);

        // enable gaps are transparent
        do_reset();
        samp(0); samp(1);
        for (int i = 0; i < 3; i++) drive(bit'(i % 2), 1'b0, 1'b0, 1'b0, 4'b0000);
        after_edge();
        chk("t4_fill0_gap", int'(fill_o[0]), 2);
        chk("t4_moore0_gap", int'(moore_o[0]), 0);
        samp(0);
        #1;
        chk("t4_mealy0_s3", int'(mealy_o[0]), 0);
        samp(1);
        #1;
        chk("t4_mealy0_s4", int'(mealy_o[0]), 1);
        after_edge();
        chk("t4_count0", int'(cnt_o[0]), 1);

        // asynchronous reset mid-stream
        do_reset();
        samp(0); samp(1); samp(0); samp(1); samp(0); samp(1);
        after_edge();
        chk("t5_moore0_pre", int'(moore_o[0]), 1);
        chk("t5_count0_pre", int'(cnt_o[0]), 2);
        #2;
        reset = 1'b0;
        en = 1'b0;
        #1;
        chk("t5_moore0_async", int'(moore_o[0]), 0);
        chk("t5_count0_async", int'(cnt_o[0]), 0);
        chk("t5_fill0_async", int'(fill_o[0]), 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        samp(1); samp(0); samp(1);
        after_edge();
        chk("t5_count0_partial", int'(cnt_o[0]), 0);
        samp(0);
        #1;
        chk("t5_mealy0_s4", int'(mealy_o[0]), 0);
        samp(1);
        #1;
        chk("t5_mealy0_s5", int'(mealy_o[0]), 1);
        after_edge();
        chk("t5_count0", int'(cnt_o[0]), 1);

        // run-time pattern load and clear priority
        do_reset();
        samp(0); samp(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1100);
        #1;
        chk("t6_mealy0_load", int'(mealy_o[0]), 0);
        after_edge();
        chk("t6_fill0_load", int'(fill_o[0]), 0);
        samp(1); samp(1); samp(0); samp(0);
        #1;
        chk("t6_mealy0_s4", int'(mealy_o[0]), 1);
        after_edge();
        chk("t6_count0", int'(cnt_o[0]), 1);
        samp(1); samp(1); samp(0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
        #1;
        chk("t6_mealy0_clr", int'(mealy_o[0]), 1);
        after_edge();
        chk("t6_count0_clr", int'(cnt_o[0]), 0);
        chk("t6_moore0_clr", int'(moore_o[0]), 1);

        // simultaneous load and clear, then the reloaded pattern works
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101);
        after_edge();
        chk("t7_fill0", int'(fill_o[0]), 0);
        chk("t7_count0", int'(cnt_o[0]), 0);
        samp(0); samp(1); samp(0); samp(1);
        after_edge();
        chk("t7_count0_match", int'(cnt_o[0]), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        #5;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
